pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Parametrised hazard and forwarding controller for the next-generation pipeline. It generalises the single-stage EX→ID forwarding to DEPTH in-flight stages with a configurable load-data latency. It adds load-use stalls, branch-shadow flush with a configurable penalty, and saturating stall/flush performance counters. It sits beside the ID stage, tracks a scoreboard of in-flight destination registers, and drives the ID operand-mux selects and the pipeline enables.

Parameters:
REG_AW, 5, register address width
DEPTH, 2, number of tracked stages after ID (entry 0 = EX, entry DEPTH-1 = WB)
LOAD_LAT, 0, lowest entry index at which load data is forwardable
SHADOW, 1, cycles flush stays asserted after a taken branch (≥1)
CNT_W, 16, performance counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a live instruction
id_aa  in  REG_AW  ID source A address
id_ba  in  REG_AW  ID source B address
id_use_a  in  1  source A read from regfile (i.e. not MA)
id_use_b  in  1  source B read from regfile (i.e. not MB)
id_rw  in  1  ID instruction writes a register
id_da  in  REG_AW  ID destination address
id_md  in  2  result source: 00 ALU, 01 memory load, 10 SLT
br_taken  in  1  EX resolves a taken branch/jump (C_SELECT≠0)
fwd_sel_a  out  $clog2(DEPTH+1)  0 = regfile, k = entry k-1
fwd_sel_b  out  $clog2(DEPTH+1)  same for B
stall  out  1  hold PC and IF/ID; bubble into EX
flush  out  1  squash IF and ID contents
stall_cnt  out  CNT_W  cycles with stall=1
flush_cnt  out  CNT_W  cycles with flush=1

Behaviour:
- Reset is asynchronous and active-low: every scoreboard entry is invalid; stall, flush, fwd_sel_a/b, stall_cnt, flush_cnt and the shadow counter are 0.
- Scoreboard entry fields: live, wr, da, ld. Each clock, entries shift from k to k+1; entry DEPTH-1 retires.
- Entry 0 load:
  - Loaded from ID only when id_valid & !stall & !flush.
  - wr = id_rw & (id_da≠0); ld = (id_md==01).
  - Otherwise entry 0 becomes a bubble (live=0, wr=0).
- Forward match for source A at entry k: entry wr=1 & da==id_aa & id_use_a. Source B is identical using id_ba / id_use_b.
- fwd_sel: the lowest matching k wins (youngest producer), giving fwd_sel = k+1. With no match, fwd_sel = 0. fwd_sel is combinational from the current scoreboard and ID inputs.
- Load-use hazard: the winning match has ld=1 and k < LOAD_LAT. Then stall=1 and fwd_sel for that operand is forced to 0. The stall releases automatically as the load advances. With LOAD_LAT=0, load-use never stalls.
- Branch:
  - br_taken is honoured only if entry 0 live=1. br_taken from a bubble is ignored.
  - An honoured br_taken asserts flush combinationally in the same cycle and loads the shadow counter with SHADOW-1.
  - flush stays 1 while the counter ≠ 0; the counter decrements each cycle.
  - An honoured br_taken during an active shadow reloads the counter.
- Simultaneous stall and flush: flush wins. stall is forced to 0 and the ID instruction is squashed, not held.
- Counters: each increments on a cycle in which its signal is 1 and saturates at all-ones (no wrap).
- Latency: the hazard/forward outputs have zero-cycle latency; scoreboard updates take effect on the next clock.
- Reset asserted mid-operation immediately clears all state, including the scoreboard and any pending shadow cycles.

Test Plan:
1. Back-to-back ALU dependency (DEPTH=2, LOAD_LAT=0): "add r3" in EX, ID reads r3 on A → fwd_sel_a=1, stall=0. One cycle later (producer in WB) → fwd_sel_a=2.
2. Destination r0, or consumer with id_use_b=0: ID reads r0, or B matches but MB selected → fwd_sel=0, no stall.
3. Load-use (LOAD_LAT=1): load r5 enters EX, ID reads r5 → stall=1 for exactly 1 cycle with fwd_sel_a=0. Next cycle fwd_sel_a=2, stall=0; stall_cnt=1.
4. Branch (SHADOW=2): br_taken with live EX → flush=1 that cycle and the next, then 0. The ID instruction never enters the scoreboard; flush_cnt=2. A br_taken pulse while entry 0 is a bubble → ignored.
5. Stall+branch collision: load-use stall and honoured br_taken in the same cycle → flush=1, stall=0, stall_cnt unchanged.
6. Counter saturation and async reset: with CNT_W=4, hold the stall condition 20 cycles → stall_cnt=15. Drop rst_n mid-cycle → all outputs 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard and forwarding controller that sits beside the ID stage. It keeps
//   a shift-register scoreboard of the destination registers still in flight
//   (entry 0 = EX ... entry DEPTH-1 = WB). From that scoreboard it drives:
//     - the ID operand-mux selects, choosing the youngest in-flight producer
//     - a load-use stall, raised when load data is not yet forwardable
//     - a branch-shadow flush, held for SHADOW cycles after a taken branch
//   It also keeps saturating counts of stall and flush cycles.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   id_valid              ID holds a live instruction
//   id_aa, id_ba          ID source register addresses
//   id_use_a, id_use_b    source is read from the register file
//   id_rw, id_da, id_md   ID write enable, destination, result source (01 = load)
//   br_taken              EX resolves a taken branch/jump
//   fwd_sel_a, fwd_sel_b  0 = register file, k = scoreboard entry k-1
//   stall                 hold PC and IF/ID, bubble into EX
//   flush                 squash IF and ID
//   stall_cnt, flush_cnt  saturating cycle counters
module pipe_hazard_ctrl #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned LOAD_LAT = 0,
  parameter int unsigned SHADOW   = 1,
  parameter int unsigned CNT_W    = 16,
  localparam int unsigned SELW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_aa,
  input  logic [REG_AW-1:0] id_ba,
  input  logic              id_use_a,
  input  logic              id_use_b,
  input  logic              id_rw,
  input  logic [REG_AW-1:0] id_da,
  input  logic [1:0]        id_md,
  input  logic              br_taken,
  output logic [SELW-1:0]   fwd_sel_a,
  output logic [SELW-1:0]   fwd_sel_b,
  output logic              stall,
  output logic              flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int unsigned SHW = $clog2(SHADOW + 1);

  // Entries whose load data is not yet forwardable (index < LOAD_LAT).
  localparam logic [DEPTH-1:0] LD_EARLY =
    (LOAD_LAT >= DEPTH) ? {DEPTH{1'b1}} : DEPTH'((64'd1 << LOAD_LAT) - 64'd1);

  logic [DEPTH-1:0]  live_q;
  logic [DEPTH-1:0]  wr_q;
  logic [DEPTH-1:0]  ld_q;
  logic [REG_AW-1:0] da_q [DEPTH];
  logic [SHW-1:0]    shadow_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_q;

  logic br_hit;
  logic haz_a;
  logic haz_b;
  logic take_id;

  always_comb begin
    fwd_sel_a = '0;
    fwd_sel_b = '0;
    haz_a     = 1'b0;
    haz_b     = 1'b0;
    // Walk from oldest to youngest so the lowest matching entry wins.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      int unsigned k;
      k = DEPTH - 1 - i;
      if (wr_q[k] && (da_q[k] == id_aa) && id_use_a) begin
        fwd_sel_a = SELW'(k + 1);
        haz_a     = ld_q[k] & LD_EARLY[k];
      end
      if (wr_q[k] && (da_q[k] == id_ba) && id_use_b) begin
        fwd_sel_b = SELW'(k + 1);
        haz_b     = ld_q[k] & LD_EARLY[k];
      end
    end
    if (haz_a) fwd_sel_a = '0;
    if (haz_b) fwd_sel_b = '0;

    // A taken branch is only real when EX holds a live instruction.
    br_hit  = br_taken & live_q[0];
    flush   = br_hit | (shadow_q != '0);
    stall   = (haz_a | haz_b) & ~flush;
    take_id = id_valid & ~stall & ~flush;
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q      <= '0;
      wr_q        <= '0;
      ld_q        <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) da_q[k] <= '0;
      shadow_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      for (int unsigned k = 1; k < DEPTH; k++) begin
        live_q[k] <= live_q[k-1];
        wr_q[k]   <= wr_q[k-1];
        ld_q[k]   <= ld_q[k-1];
        da_q[k]   <= da_q[k-1];
      end
      live_q[0] <= take_id;
      wr_q[0]   <= take_id & id_rw & (id_da != '0);
      ld_q[0]   <= take_id & (id_md == 2'b01);
      da_q[0]   <= id_da;

      if (br_hit)                shadow_q <= SHW'(SHADOW - 1);
      else if (shadow_q != '0)   shadow_q <= shadow_q - 1'b1;

      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid;
    logic [4:0] aa;
    logic [4:0] ba;
    logic       ua;
    logic       ub;
    logic       rw;
    logic [4:0] da;
    logic [1:0] md;
    logic       br;
  } in_t;

  typedef struct packed {
    logic [1:0]  sa;
    logic [1:0]  sb;
    logic        st;
    logic        fl;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  in_t in_a;
  in_t in_b;

  logic [1:0]  a_sa, a_sb, b_sa, b_sb;
  logic        a_st, a_fl, b_st, b_fl;
  logic [15:0] a_sc, a_fc;
  logic [3:0]  b_sc, b_fc;

  // Instance A: default geometry (LOAD_LAT=0, SHADOW=1, CNT_W=16)
  pipe_hazard_ctrl #(.REG_AW(5), .DEPTH(2), .LOAD_LAT(0), .SHADOW(1), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .id_valid(in_a.valid), .id_aa(in_a.aa), .id_ba(in_a.ba),
    .id_use_a(in_a.ua), .id_use_b(in_a.ub), .id_rw(in_a.rw), .id_da(in_a.da),
    .id_md(in_a.md), .br_taken(in_a.br), .fwd_sel_a(a_sa), .fwd_sel_b(a_sb),
    .stall(a_st), .flush(a_fl), .stall_cnt(a_sc), .flush_cnt(a_fc));

  // Instance B: LOAD_LAT=1, SHADOW=2, CNT_W=4
  pipe_hazard_ctrl #(.REG_AW(5), .DEPTH(2), .LOAD_LAT(1), .SHADOW(2), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .id_valid(in_b.valid), .id_aa(in_b.aa), .id_ba(in_b.ba),
    .id_use_a(in_b.ua), .id_use_b(in_b.ub), .id_rw(in_b.rw), .id_da(in_b.da),
    .id_md(in_b.md), .br_taken(in_b.br), .fwd_sel_a(b_sa), .fwd_sel_b(b_sb),
    .stall(b_st), .flush(b_fl), .stall_cnt(b_sc), .flush_cnt(b_fc));

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  function automatic in_t mk(input logic v, input logic [4:0] aa, input logic [4:0] ba,
                             input logic ua, input logic ub, input logic rw,
                             input logic [4:0] da, input logic [1:0] md, input logic br);
    in_t r;
    r.valid = v; r.aa = aa; r.ba = ba; r.ua = ua; r.ub = ub;
    r.rw = rw; r.da = da; r.md = md; r.br = br;
    return r;
  endfunction

  function automatic exp_t ex(input logic [1:0] sa, input logic [1:0] sb, input logic st,
                              input logic fl, input int sc, input int fc);
    exp_t r;
    r.sa = sa; r.sb = sb; r.st = st; r.fl = fl; r.sc = 16'(sc); r.fc = 16'(fc);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_out(input bit which, input string tag, input exp_t e);
    if (which) begin
      chk({tag, ".sel_a"}, 16'(b_sa), 16'(e.sa));
      chk({tag, ".sel_b"}, 16'(b_sb), 16'(e.sb));
      chk({tag, ".stall"}, 16'(b_st), 16'(e.st));
      chk({tag, ".flush"}, 16'(b_fl), 16'(e.fl));
      chk({tag, ".stall_cnt"}, {12'b0, b_sc}, e.sc);
      chk({tag, ".flush_cnt"}, {12'b0, b_fc}, e.fc);
    end else begin
      chk({tag, ".sel_a"}, 16'(a_sa), 16'(e.sa));
      chk({tag, ".sel_b"}, 16'(a_sb), 16'(e.sb));
      chk({tag, ".stall"}, 16'(a_st), 16'(e.st));
      chk({tag, ".flush"}, 16'(a_fl), 16'(e.fl));
      chk({tag, ".stall_cnt"}, a_sc, e.sc);
      chk({tag, ".flush_cnt"}, a_fc, e.fc);
    end
  endtask

  // Drive one cycle of ID/EX inputs, queue what the outputs must be in that
  // cycle, compare mid-cycle, then let the clock edge commit the state.
  task automatic step(input bit which, input in_t v, input exp_t e, input string tag);
    exp_t  x;
    string t;
    if (which) in_b = v; else in_a = v;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    x = exp_q.pop_front();
    t = tag_q.pop_front();
    check_out(which, t, x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t ld5;
    in_a = '0;
    in_b = '0;
    rst_n = 1'b0;
    #12;
    check_out(0, "rstA", ex(0, 0, 0, 0, 0, 0));
    check_out(1, "rstB", ex(0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ALU forwarding, r0 and use-flag filtering, LOAD_LAT=0, SHADOW=1
    step(0, mk(1, 0, 0, 0, 0, 1, 3, 0, 0), ex(0, 0, 0, 0, 0, 0), "A1_add_r3");
    step(0, mk(1, 3, 0, 1, 0, 0, 0, 0, 0), ex(1, 0, 0, 0, 0, 0), "A2_fwd_ex");
    step(0, mk(1, 3, 3, 1, 1, 0, 0, 0, 0), ex(2, 2, 0, 0, 0, 0), "A3_fwd_wb");
    step(0, mk(1, 3, 3, 1, 1, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0), "A4_retired");
    step(0, mk(1, 0, 0, 0, 0, 1, 0, 0, 0), ex(0, 0, 0, 0, 0, 0), "A5_wr_r0");
    step(0, mk(1, 0, 0, 1, 1, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0), "A6_rd_r0");
    step(0, mk(1, 0, 0, 0, 0, 1, 7, 0, 0), ex(0, 0, 0, 0, 0, 0), "A7_add_r7");
    step(0, mk(1, 7, 7, 1, 0, 0, 0, 0, 0), ex(1, 0, 0, 0, 0, 0), "A8_mb_sel");
    step(0, mk(1, 0, 0, 0, 0, 1, 9, 1, 0), ex(0, 0, 0, 0, 0, 0), "A9_ld_r9");
    step(0, mk(1, 9, 0, 1, 0, 0, 0, 0, 0), ex(1, 0, 0, 0, 0, 0), "A10_ld_nostall");
    step(0, mk(1, 0, 0, 0, 0, 1, 4, 0, 1), ex(0, 0, 0, 1, 0, 0), "A11_br");
    step(0, mk(0, 4, 0, 1, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 1), "A12_squashed");
    step(0, mk(0, 0, 0, 0, 0, 0, 0, 0, 1), ex(0, 0, 0, 0, 0, 1), "A13_br_bubble");
    step(0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 1), "A14_idle");
    in_a = '0;

    // Load-use stall, SHADOW=2 flush, collision, LOAD_LAT=1
    step(1, mk(1, 0, 0, 0, 0, 1, 5, 1, 0), ex(0, 0, 0, 0, 0, 0), "B1_ld_r5");
    step(1, mk(1, 5, 0, 1, 0, 1, 6, 0, 0), ex(0, 0, 1, 0, 0, 0), "B2_lduse");
    step(1, mk(1, 5, 0, 1, 0, 1, 6, 0, 0), ex(2, 0, 0, 0, 1, 0), "B3_release");
    step(1, mk(1, 5, 6, 1, 1, 0, 0, 0, 0), ex(0, 1, 0, 0, 1, 0), "B4_held_entered");
    step(1, mk(1, 0, 0, 0, 0, 1, 8, 0, 1), ex(0, 0, 0, 1, 1, 0), "B5_br");
    step(1, mk(1, 0, 0, 0, 0, 1, 8, 0, 0), ex(0, 0, 0, 1, 1, 1), "B6_shadow");
    step(1, mk(1, 8, 0, 1, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 1, 2), "B7_shadow_end");
    step(1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 1, 2), "B8_idle");
    step(1, mk(0, 0, 0, 0, 0, 0, 0, 0, 1), ex(0, 0, 0, 0, 1, 2), "B9_br_bubble");
    step(1, mk(1, 0, 0, 0, 0, 1, 5, 1, 0), ex(0, 0, 0, 0, 1, 2), "B10_ld_r5");
    step(1, mk(1, 5, 0, 1, 0, 0, 0, 0, 1), ex(0, 0, 0, 1, 1, 2), "B11_collide");
    step(1, mk(1, 5, 0, 1, 0, 0, 0, 0, 0), ex(2, 0, 0, 1, 1, 3), "B12_shadow");
    step(1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 1, 4), "B13_idle");

    // Self-dependent loads alternate stall / issue; counter saturates at 15.
    ld5 = mk(1, 5, 0, 1, 0, 1, 5, 1, 0);
    for (int i = 0; i <= 40; i++) begin
      int sc;
      sc = 1 + i / 2;
      if (sc > 15) sc = 15;
      step(1, ld5,
           ex((i == 0 || (i % 2) == 1) ? 2'd0 : 2'd2, 2'd0, (i % 2) == 1, 1'b0, sc, 4),
           $sformatf("B_sat%0d", i));
    end

    // Asynchronous reset mid-cycle with a live flush and counters non-zero.
    in_b = mk(1, 5, 0, 1, 0, 0, 0, 0, 1);
    #1;
    chk("pre_rst.flush", 16'(b_fl), 16'd1);
    chk("pre_rst.sel_a", 16'(b_sa), 16'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_out(1, "async_rstB", ex(0, 0, 0, 0, 0, 0));
    check_out(0, "async_rstA", ex(0, 0, 0, 0, 0, 0));
    in_b = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    step(1, mk(1, 5, 0, 1, 0, 0, 0, 0, 1), ex(0, 0, 0, 0, 0, 0), "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
